// File: rtl/mem_access.sv
// Memory stage: turns a datapath load/store into a req/ack transaction on a
// word-addressed big-endian data bus. It holds the pipeline in stall until
// the bus answers or the ack-wait timeout expires.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUout,
  input  logic [31:0] busB,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memSigned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] MEMout,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, nextState;
  logic [7:0]  waitCount;
  logic [1:0]  reqSize;
  logic [1:0]  reqOffset;
  logic        reqSigned;
  logic        reqLoad;
  logic        access;
  logic        startReq;
  logic        timeoutHit;

  // Byte enables for a request; bit 3 is the lane at byte offset 0.
  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] off);
    if (size[1])          return 4'b1111;
    else if (size[0])     return off[1] ? 4'b0011 : 4'b1100;
    else                  return 4'b1000 >> off;
  endfunction

  // Replicate right-justified store data onto every lane it could occupy.
  function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] data);
    if (size[1])          return data;
    else if (size[0])     return {2{data[15:0]}};
    else                  return {4{data[7:0]}};
  endfunction

  // Pick the addressed lane(s) out of a bus word and extend to 32 bits.
  function automatic logic [31:0] extendLoad(input logic [31:0] rdata, input logic [1:0] size,
                                             input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[31:24];
      2'd1:    b = rdata[23:16];
      2'd2:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[15:0] : rdata[31:16];
    if (size[1])          return rdata;
    else if (size[0])     return {{16{sgn & h[15]}}, h};
    else                  return {{24{sgn & b[7]}}, b};
  endfunction

  assign access     = memRead | memWrite;
  assign misaligned = (state == IDLE) && access &&
                      (((memSize == 2'b01) && ALUout[0]) || (memSize[1] && (ALUout[1:0] != 2'b00)));
  assign startReq   = (state == IDLE) && access && !misaligned;
  // An ack on the last wait cycle takes priority over the timeout.
  assign timeoutHit = (state == BUSY) && !mem_ack && (waitCount == 8'(TIMEOUT - 1));

  // Next-state and stall decode.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = startReq;
        if (startReq) nextState = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack || timeoutHit) nextState = DONE;
      end
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Bus interface, request context, timeout counter and load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      MEMout    <= '0;
      bus_err   <= 1'b0;
      waitCount <= '0;
      reqSize   <= '0;
      reqOffset <= '0;
      reqSigned <= 1'b0;
      reqLoad   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (startReq) begin
        mem_req   <= 1'b1;
        mem_we    <= memWrite;
        mem_addr  <= {ALUout[31:2], 2'b00};
        mem_be    <= byteEnable(memSize, ALUout[1:0]);
        mem_wdata <= laneData(memSize, busB);
        waitCount <= '0;
        reqSize   <= memSize;
        reqOffset <= ALUout[1:0];
        reqSigned <= memSigned;
        reqLoad   <= !memWrite;
      end else if (state == BUSY) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (reqLoad) MEMout <= extendLoad(mem_rdata, reqSize, reqOffset, reqSigned);
        end else if (timeoutHit) begin
          mem_req <= 1'b0;
          bus_err <= 1'b1;
          if (reqLoad) MEMout <= '0;
        end else begin
          waitCount <= waitCount + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: drives load/store requests, plays the bus
// side by hand and compares outputs against hand-computed values.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUout, busB, mem_rdata;
  logic        memRead, memWrite, memSigned, mem_ack;
  logic [1:0]  memSize;
  logic        mem_req, mem_we, stall, misaligned, bus_err;
  logic [31:0] mem_addr, mem_wdata, MEMout;
  logic [3:0]  mem_be;

  int nChecks = 0;
  int nPass   = 0;

  // Bus signals captured in the first BUSY cycle of the last access.
  logic        cReq, cWe;
  logic [31:0] cAddr, cWdata;
  logic [3:0]  cBe;
  int          stallCnt;
  int          busyCnt;

  mem_access #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ALUout(ALUout), .busB(busB),
    .memRead(memRead), .memWrite(memWrite), .memSize(memSize), .memSigned(memSigned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .MEMout(MEMout), .stall(stall), .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] wd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic sg);
    ALUout = addr; busB = wd; memRead = rd; memWrite = wr; memSize = sz; memSigned = sg;
    #1;
  endtask

  // Request must already be presented in IDLE; ack arrives in BUSY cycle nBusy.
  // Returns in DONE, 1 time unit after the edge.
  task automatic runAccess(input int nBusy, input logic [31:0] rdata);
    stallCnt = stall ? 1 : 0;
    tick();
    memRead = 1'b0; memWrite = 1'b0;
    cReq = mem_req; cWe = mem_we; cAddr = mem_addr; cBe = mem_be; cWdata = mem_wdata;
    for (int i = 1; i <= nBusy; i++) begin
      if (i == nBusy) begin mem_rdata = rdata; mem_ack = 1'b1; end
      #1;
      if (stall) stallCnt++;
      tick();
    end
    mem_ack = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    ALUout = '0; busB = '0; memRead = 1'b0; memWrite = 1'b0; memSize = 2'b00; memSigned = 1'b0;
    tick(); tick();
    check("rst_req",    {31'd0, mem_req}, 32'd0);
    check("rst_we",     {31'd0, mem_we}, 32'd0);
    check("rst_addr",   mem_addr, 32'd0);
    check("rst_be",     {28'd0, mem_be}, 32'd0);
    check("rst_wdata",  mem_wdata, 32'd0);
    check("rst_memout", MEMout, 32'd0);
    check("rst_buserr", {31'd0, bus_err}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_stall", {31'd0, stall}, 32'd0);

    // Word load, ack in third BUSY cycle.
    issue(32'h100, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    check("wl_misal", {31'd0, misaligned}, 32'd0);
    runAccess(3, 32'hDEADBEEF);
    check("wl_req",   {31'd0, cReq}, 32'd1);
    check("wl_we",    {31'd0, cWe}, 32'd0);
    check("wl_addr",  cAddr, 32'h100);
    check("wl_be",    {28'd0, cBe}, 32'hF);
    check("wl_stalls", stallCnt, 32'd4);
    check("wl_done_stall", {31'd0, stall}, 32'd0);
    check("wl_done_req", {31'd0, mem_req}, 32'd0);
    check("wl_memout", MEMout, 32'hDEADBEEF);
    tick();

    // Signed byte load at offset 3, ack on first BUSY cycle.
    issue(32'h203, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1);
    runAccess(1, 32'h112233F0);
    check("sb_addr",  cAddr, 32'h200);
    check("sb_be",    {28'd0, cBe}, 32'h1);
    check("sb_stalls", stallCnt, 32'd2);
    check("sb_memout", MEMout, 32'hFFFFFFF0);
    tick();

    // Unsigned repeat.
    issue(32'h203, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0);
    runAccess(1, 32'h112233F0);
    check("ub_memout", MEMout, 32'h000000F0);
    tick();

    // Signed byte at offset 0 with a positive value.
    issue(32'h300, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1);
    runAccess(2, 32'h7F8899AA);
    check("sb0_be",   {28'd0, cBe}, 32'h8);
    check("sb0_memout", MEMout, 32'h0000007F);
    tick();

    // Signed half load at offset 2.
    issue(32'h302, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1);
    runAccess(1, 32'h12348001);
    check("sh_be",    {28'd0, cBe}, 32'h3);
    check("sh_memout", MEMout, 32'hFFFF8001);
    tick();

    // Unsigned half load at offset 0.
    issue(32'h300, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    runAccess(1, 32'hBEEF0001);
    check("uh_be",    {28'd0, cBe}, 32'hC);
    check("uh_memout", MEMout, 32'h0000BEEF);
    tick();

    // Half store leaves MEMout alone.
    issue(32'h42, 32'h0000ABCD, 1'b0, 1'b1, 2'b01, 1'b0);
    runAccess(1, 32'h99999999);
    check("hs_we",    {31'd0, cWe}, 32'd1);
    check("hs_addr",  cAddr, 32'h40);
    check("hs_be",    {28'd0, cBe}, 32'h3);
    check("hs_wdata", cWdata, 32'hABCDABCD);
    check("hs_memout", MEMout, 32'h0000BEEF);
    tick();

    // Byte store at offset 1.
    issue(32'h51, 32'h123456C3, 1'b0, 1'b1, 2'b00, 1'b0);
    runAccess(1, 32'd0);
    check("bs_be",    {28'd0, cBe}, 32'h4);
    check("bs_wdata", cWdata, 32'hC3C3C3C3);
    tick();

    // Misaligned word and half accesses.
    issue(32'h101, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    check("mw_misal", {31'd0, misaligned}, 32'd1);
    check("mw_stall", {31'd0, stall}, 32'd0);
    tick();
    check("mw_req",   {31'd0, mem_req}, 32'd0);
    check("mw_memout", MEMout, 32'h0000BEEF);
    issue(32'h43, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    check("mh_misal", {31'd0, misaligned}, 32'd1);
    issue(32'h42, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    check("ah_misal", {31'd0, misaligned}, 32'd0);
    memRead = 1'b0;
    #1;
    check("noacc_misal", {31'd0, misaligned}, 32'd0);
    tick();

    // Load with no ack times out after 16 BUSY cycles.
    issue(32'h10, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    tick();
    memRead = 1'b0;
    busyCnt = 0;
    while (mem_req && busyCnt < 40) begin
      check("to_noerr", {31'd0, bus_err}, 32'd0);
      busyCnt++;
      tick();
    end
    check("to_cycles", busyCnt, 32'd16);
    check("to_buserr", {31'd0, bus_err}, 32'd1);
    check("to_stall",  {31'd0, stall}, 32'd0);
    check("to_memout", MEMout, 32'd0);
    tick();
    check("to_errpulse", {31'd0, bus_err}, 32'd0);
    check("to_idle_stall", {31'd0, stall}, 32'd0);

    // Ack on the timeout edge: ack wins.
    issue(32'h14, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    runAccess(16, 32'h0BADF00D);
    check("tw_buserr", {31'd0, bus_err}, 32'd0);
    check("tw_memout", MEMout, 32'h0BADF00D);
    tick();

    // Reset in BUSY aborts; later ack is ignored.
    issue(32'h20, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    tick();
    memRead = 1'b0;
    check("ra_req_busy", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("ra_req",    {31'd0, mem_req}, 32'd0);
    check("ra_memout", MEMout, 32'd0);
    check("ra_stall",  {31'd0, stall}, 32'd0);
    tick();
    reset = 1'b0;
    mem_rdata = 32'h55555555; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    check("ra_ack_req",    {31'd0, mem_req}, 32'd0);
    check("ra_ack_stall",  {31'd0, stall}, 32'd0);
    check("ra_ack_memout", MEMout, 32'd0);

    // Read and write both set: store wins.
    issue(32'h80, 32'h55AA33CC, 1'b1, 1'b1, 2'b11, 1'b1);
    runAccess(1, 32'h77777777);
    check("rw_we",    {31'd0, cWe}, 32'd1);
    check("rw_be",    {28'd0, cBe}, 32'hF);
    check("rw_wdata", cWdata, 32'h55AA33CC);
    check("rw_memout", MEMout, 32'd0);
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage between execute and writeback.
- Accepts a load/store request from the datapath and runs a multi-cycle req/ack transaction on a 32-bit word-addressed external data bus.
- Stalls the pipeline until the bus answers.
- Returns aligned, size-extended load data on MEMout, which writeback selects when memToReg is set.

Parameters:
TIMEOUT, 16, ack-wait cycles in BUSY before the bus error abort (1..255)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
ALUout  input  32  effective byte address
busB  input  32  store data, right-justified
memRead  input  1  load request
memWrite  input  1  store request
memSize  input  2  00 byte, 01 half, 10/11 word
memSigned  input  1  1 = sign-extend loads, 0 = zero-extend
mem_req  output  1  bus request, registered
mem_we  output  1  bus write enable, registered
mem_addr  output  32  word address {ALUout[31:2],2'b00}, registered
mem_be  output  4  byte enables, bit3 = bits 31:24, registered
mem_wdata  output  32  store data replicated to lanes, registered
mem_rdata  input  32  bus read data
mem_ack  input  1  bus completion, one-cycle pulse
MEMout  output  32  load result, registered
stall  output  1  pipeline hold
misaligned  output  1  alignment fault, combinational
bus_err  output  1  timeout fault, one-cycle pulse, registered

Behaviour:
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, MEMout=0, bus_err=0, state=IDLE, timeout counter=0.
- Reset asserted mid-transaction aborts immediately. A pending ack is then ignored.
- Access = memRead | memWrite. If both are set, the access is a store (write wins).
- Byte order is big-endian: offset 0 maps to lane bits 31:24.
- Alignment:
  - misaligned=1 in IDLE when an access is present and either memSize=01 with ALUout[0]=1, or memSize is word with ALUout[1:0]!=0.
  - A misaligned access issues no bus request and does not stall.
  - MEMout holds its value.
- Byte enables:
  - Byte: one-hot from offset, 0→1000, 3→0001.
  - Half: offset 0→1100, offset 2→0011.
  - Word: 1111.
- mem_wdata:
  - Byte: {4{busB[7:0]}}.
  - Half: {2{busB[15:0]}}.
  - Word: busB.
- State IDLE:
  - On an aligned access, latch mem_addr/mem_be/mem_wdata/mem_we, set mem_req=1, clear the counter, go to BUSY.
  - stall=1 combinationally in this cycle.
- State BUSY:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable; stall=1.
  - On mem_ack: mem_req←0. For a load, MEMout←selected lanes, extended per memSigned latched at request (store leaves MEMout unchanged). Go to DONE.
  - Without ack: the counter increments. When counter==TIMEOUT-1 with no ack, mem_req←0, bus_err←1 for one cycle, MEMout←0 if the access is a load. Go to DONE.
  - Ack on the same edge as the timeout: ack wins, no bus_err.
- State DONE:
  - stall=0 for exactly one cycle so the pipeline advances. Unconditionally return to IDLE; no new request is accepted this cycle.
- Latency: a load with ack in the first BUSY cycle shows MEMout valid in DONE, 2 cycles after the request is presented. Total stall cycles = 1 + BUSY cycles.
- Extension:
  - Byte extends from bit 7 of the selected lane.
  - Half extends from bit 15 of the selected halfword.
  - Word passes through unchanged.
- mem_ack while IDLE or DONE is ignored.

Test Plan:
- Word load at 0x100, ack after 3 BUSY cycles, rdata=0xDEADBEEF → mem_addr=0x100, be=1111, stall high 4 cycles, MEMout=0xDEADBEEF in DONE.
- Signed byte load at 0x203, rdata=0x112233F0 → be=0001, MEMout=0xFFFFFFF0. Unsigned repeat → MEMout=0x000000F0.
- Half store at 0x42, busB=0x0000ABCD → mem_we=1, mem_addr=0x40, be=0011, wdata=0xABCDABCD, MEMout unchanged.
- Word load at 0x101 → misaligned=1, mem_req stays 0, stall=0.
- Load with no ack, TIMEOUT=16 → mem_req drops after 16 BUSY cycles, bus_err pulses once, MEMout=0, then DONE and IDLE.
- Reset asserted in BUSY, then ack arrives → mem_req=0 immediately, state IDLE, MEMout=0, ack ignored.
- memRead=memWrite=1 → store performed (mem_we=1).
